program_counter_unit: RTL

//  Holds the 16-bit program counter and runs the instruction-fetch handshake to instruction memory.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pc_next_calc.sv | 28 ++
 rtl/program_counter_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address widths, reset vector, fetch FSM states and
// instruction field positions, plus a sign-extension helper.
package cpu_pkg;

  localparam int unsigned ADDR_WIDTH   = 16;
  localparam int unsigned DISP_WIDTH   = 8;
  localparam int unsigned INSTR_WIDTH  = 16;
  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RUN  = 2'd3
  } fetch_state_t;

  // Instruction word layout: opcode | rd | immediateHigh | immediateLow
  localparam int unsigned OPCODE_MSB   = 15;
  localparam int unsigned OPCODE_LSB   = 12;
  localparam int unsigned RD_MSB       = 11;
  localparam int unsigned RD_LSB       = 8;
  localparam int unsigned IMM_HIGH_MSB = 7;
  localparam int unsigned IMM_HIGH_LSB = 4;
  localparam int unsigned IMM_LOW_MSB  = 3;
  localparam int unsigned IMM_LOW_LSB  = 0;

  function automatic logic [ADDR_WIDTH-1:0] sext_disp(input logic [DISP_WIDTH-1:0] d);
    return {{(ADDR_WIDTH - DISP_WIDTH){d[DISP_WIDTH-1]}}, d};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump target beats branch (PC + sign-extended displacement),
// which beats sequential increment. All sums wrap at ADDR_WIDTH.
module pc_next_calc #(
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int unsigned DISP_WIDTH = cpu_pkg::DISP_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [DISP_WIDTH-1:0] disp,
  input  logic [ADDR_WIDTH-1:0] regTarget,
  input  logic                  jumpReg,
  input  logic                  branchMux,
  output logic [ADDR_WIDTH-1:0] pcNext
);

  logic [ADDR_WIDTH-1:0] w_disp_ext;

  assign w_disp_ext = {{(ADDR_WIDTH - DISP_WIDTH){disp[DISP_WIDTH-1]}}, disp};

  always_comb begin
    pcNext = pc + ADDR_WIDTH'(1);
    if (jumpReg) begin
      pcNext = regTarget;
    end else if (branchMux) begin
      pcNext = pc + w_disp_ext;
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter and instruction-fetch handshake. Optional return-address
// link register is built only when PC_LINK_EN is defined.
module program_counter_unit #(
  parameter int unsigned           ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
  parameter int unsigned           DISP_WIDTH   = cpu_pkg::DISP_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(cpu_pkg::RESET_VECTOR)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pcEnabled,
  input  logic                  branchMux,
  input  logic                  jumpReg,
  input  logic [DISP_WIDTH-1:0] disp,
  input  logic [ADDR_WIDTH-1:0] regTarget,
  input  logic                  pcOrRegMemMUX,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic                  instrAck,
  input  logic [15:0]           instrData,
  input  logic                  linkCapture,
  output logic                  instrReq,
  output logic [ADDR_WIDTH-1:0] memAddrA,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           instruction,
  output logic                  instrValid,
  output logic                  pcError,
  output logic [ADDR_WIDTH-1:0] linkAddr
);

  import cpu_pkg::*;

  fetch_state_t          r_state;
  fetch_state_t          w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [15:0]           r_instr;
  logic                  r_valid;
  logic                  r_err;
  logic                  w_fetch_done;
  logic                  w_commit;
  logic                  w_req;

  pc_next_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DISP_WIDTH (DISP_WIDTH)
  ) u_next (
    .pc        (r_pc),
    .disp      (disp),
    .regTarget (regTarget),
    .jumpReg   (jumpReg),
    .branchMux (branchMux),
    .pcNext    (w_pc_next)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_REQ;
      S_REQ:   w_next_state = S_WAIT;
      S_WAIT:  if (instrAck) w_next_state = S_RUN;
      S_RUN:   if (pcEnabled) w_next_state = S_REQ;
      default: w_next_state = S_BOOT;
    endcase
  end

  // The fetch address always wins during the request cycle, whatever the mux says.
  always_comb begin
    w_req        = (r_state == S_REQ);
    w_fetch_done = (r_state == S_WAIT) && instrAck;
    w_commit     = (r_state == S_RUN) && pcEnabled;
    memAddrA     = r_pc;
    if (!w_req && pcOrRegMemMUX) begin
      memAddrA = dataAddr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_fetch_done;
      if (w_commit) begin
        r_pc <= w_pc_next;
      end
      if (w_fetch_done) begin
        r_instr <= instrData;
      end
      if (pcEnabled && (r_state != S_RUN)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef PC_LINK_EN
  logic [ADDR_WIDTH-1:0] r_link;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_link <= '0;
    end else if (w_commit && jumpReg && linkCapture) begin
      r_link <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign linkAddr = r_link;
`else
  logic w_unused_link;

  assign w_unused_link = linkCapture;
  assign linkAddr      = '0;
`endif

  assign instrReq    = w_req;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instrValid  = r_valid;
  assign pcError     = r_err;

endmodule
